// File: rtl/instr_loader.sv
// instr_loader: assembles a serial byte stream into big-endian instruction
// words and writes them to sequential instruction-memory addresses until the
// halt word arrives (DONE, o_valid) or memory fills up without one (ERROR).
module instr_loader #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_loading,
    output logic               o_valid,
    output logic               o_error,
    output logic [NB_ADDR:0]   o_word_count
);

    localparam int                 NB_ASM    = NB_DATA - NB_BYTE;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;
    localparam logic [NB_ADDR-1:0] PTR_ONE   = 1;
    localparam logic [NB_ADDR:0]   WC_ONE    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ADDR-1:0]  ptr_q, ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [NB_ASM-1:0]   asm_q, asm_d;
    logic                wr_en_q, wr_en_d;
    logic [NB_ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [NB_DATA-1:0]  wr_data_q, wr_data_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic [NB_ADDR:0]    wc_q, wc_d;
    logic [NB_DATA-1:0]  full_word;

    // Next-state logic: i_start overrides everything, including a byte strobe
    // in the same cycle; the 4th byte of a word produces the write pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        valid_d   = valid_q;
        error_d   = error_q;
        wc_d      = wc_q;
        full_word = {asm_q, i_rx_data};

        if (i_start) begin
            state_d = LOAD;
            ptr_d   = '0;
            cnt_d   = '0;
            asm_d   = '0;
            wc_d    = '0;
            valid_d = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (i_rx_done) begin
                        if (cnt_q == 2'd3) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = full_word;
                            wc_d      = wc_q + WC_ONE;
                            cnt_d     = '0;
                            asm_d     = '0;
                            // Pointer saturates at the last address; the load
                            // always ends there, so it never wraps within a load.
                            ptr_d     = (ptr_q == LAST_ADDR) ? ptr_q : ptr_q + PTR_ONE;
                            if (full_word == HALT_WORD) begin
                                state_d = DONE;
                            end else if (ptr_q == LAST_ADDR) begin
                                state_d = ERROR;
                                error_d = 1'b1;
                            end
                        end else begin
                            asm_d = full_word[NB_ASM-1:0];
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                // Valid rises one cycle after the halt write pulse so the
                // memory write has committed before fetch starts.
                DONE:    valid_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            asm_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            wc_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            wc_q      <= wc_d;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_loading    = (state_q == LOAD);
    assign o_valid      = valid_q;
    assign o_error      = error_q;
    assign o_word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: drives one byte stream into a 256-word and a 4-word
// instance and compares both against a transaction-level loader model.
module tb_instr_loader;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0, i_start = 1'b0, i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = '0;

    logic        en0, l0, v0, e0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic [8:0]  wc0;
    logic        en1, l1, v1, e1;
    logic [1:0]  a1;
    logic [31:0] d1;
    logic [2:0]  wc1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_loader #(.NB_ADDR(8)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_wr_en(en0), .o_wr_addr(a0), .o_wr_data(d0), .o_loading(l0),
        .o_valid(v0), .o_error(e0), .o_word_count(wc0)
    );

    instr_loader #(.NB_ADDR(2)) dut_s (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_wr_en(en1), .o_wr_addr(a1), .o_wr_data(d1), .o_loading(l1),
        .o_valid(v1), .o_error(e1), .o_word_count(wc1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a loader is either loading, done or errored; bytes are
    // accumulated arithmetically and every completed word becomes an expected write.
    bit          m_act[2], m_done[2], m_err[2];
    int          m_ptr[2], m_nb[2];
    logic [31:0] m_word[2];
    int          m_max[2] = '{256, 4};
    logic [39:0] q0[$], q1[$];
    bit          pend[2];

    task automatic model(input bit rst, input bit st, input bit rx, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_done[k] = 0; m_err[k] = 0; m_ptr[k] = 0; m_nb[k] = 0; m_word[k] = 0;
            end else if (st) begin
                m_act[k] = 1; m_done[k] = 0; m_err[k] = 0; m_ptr[k] = 0; m_nb[k] = 0; m_word[k] = 0;
            end else if (m_act[k] && rx) begin
                m_word[k] = (m_word[k] << 8) | {24'd0, d};
                m_nb[k]++;
                if (m_nb[k] == 4) begin
                    if (k == 0) q0.push_back({m_ptr[k][7:0], m_word[k]});
                    else        q1.push_back({m_ptr[k][7:0], m_word[k]});
                    m_ptr[k]++;
                    m_nb[k] = 0;
                    if (m_word[k] == HALT) begin
                        m_act[k] = 0; m_done[k] = 1;
                    end else if (m_ptr[k] == m_max[k]) begin
                        m_act[k] = 0; m_err[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic mon(input int k, input logic en, input logic [7:0] a, input logic [31:0] d,
                       input logic v, input logic l);
        logic [39:0] e;
        int          qs;
        if (pend[k]) begin
            chk($sformatf("valid_rise%0d", k), v, 1);
            pend[k] = 0;
        end
        if (en) begin
            qs = (k == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                chk($sformatf("wr_spurious%0d", k), en, 0);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("wr_addr%0d", k), a, e[39:32]);
                chk($sformatf("wr_data%0d", k), d, e[31:0]);
                if (d == HALT) begin
                    chk($sformatf("valid_at_halt%0d", k), v, 0);
                    chk($sformatf("loading_at_halt%0d", k), l, 0);
                    pend[k] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, en0, a0, d0, v0, l0);
        mon(1, en1, {6'd0, a1}, d1, v1, l1);
    end

    task automatic cyc(input bit rst, input bit st, input bit rx, input logic [7:0] d);
        i_reset = rst; i_start = st; i_rx_done = rx; i_rx_data = d;
        @(posedge clk);
        model(rst, st, rx, d);
        #1;
        i_reset = 0; i_start = 0; i_rx_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int b = 3; b >= 0; b--) begin
            cyc(0, 0, 1, w[b*8 +: 8]);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h12345678;
        return w;
    endfunction

    task automatic check_flags(input string tag);
        idle(3);
        chk({tag, "_valid0"}, v0, m_done[0]);
        chk({tag, "_error0"}, e0, m_err[0]);
        chk({tag, "_loading0"}, l0, m_act[0]);
        chk({tag, "_wc0"}, wc0, m_ptr[0]);
        chk({tag, "_pending0"}, q0.size(), 0);
        chk({tag, "_valid1"}, v1, m_done[1]);
        chk({tag, "_error1"}, e1, m_err[1]);
        chk({tag, "_loading1"}, l1, m_act[1]);
        chk({tag, "_wc1"}, wc1, m_ptr[1]);
        chk({tag, "_pending1"}, q1.size(), 0);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        @(negedge clk);
        chk("rst_outputs0", {en0, a0, d0, l0, v0, e0, wc0}, '0);
        chk("rst_outputs1", {en1, a1, d1, l1, v1, e1, wc1}, '0);

        // Basic load: one word then halt
        cyc(0, 1, 0, 8'h00);
        send_word(32'h20080005, 1);
        send_word(HALT, 1);
        check_flags("t1");

        // Back-to-back bytes, three words plus halt
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) send_word(rnd_word(), 0);
        send_word(HALT, 0);
        check_flags("t2");

        // Restart mid-word discards the partial word
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h11);
        cyc(0, 0, 1, 8'h22);
        cyc(0, 1, 0, 8'h00);
        send_word(32'h8C010004, 1);
        send_word(HALT, 1);
        check_flags("t3");

        // Memory fill without halt (small instance errors, extra bytes ignored)
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) send_word(rnd_word(), 1);
        idle(2);
        chk("t4_error1", e1, 1);
        chk("t4_valid1", v1, 0);
        send_word(rnd_word(), 0);
        check_flags("t4a");
        // Halt as the last word of the small memory
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) send_word(rnd_word(), 1);
        send_word(HALT, 1);
        check_flags("t4b");

        // Reset after three bytes of a word
        cyc(0, 1, 0, 8'h00);
        send_word(rnd_word(), 1);
        cyc(0, 0, 1, 8'hA1);
        cyc(0, 0, 1, 8'hA2);
        cyc(0, 0, 1, 8'hA3);
        cyc(1, 0, 0, 8'h00);
        @(negedge clk);
        chk("t5_outputs0", {en0, a0, d0, l0, v0, e0, wc0}, '0);
        chk("t5_outputs1", {en1, a1, d1, l1, v1, e1, wc1}, '0);
        send_word(rnd_word(), 0);
        check_flags("t5");

        // Start from DONE together with a byte strobe
        cyc(0, 1, 0, 8'h00);
        send_word(rnd_word(), 1);
        send_word(HALT, 1);
        check_flags("t6a");
        cyc(0, 1, 1, 8'hAB);
        @(negedge clk);
        chk("t6_valid0", v0, 0);
        chk("t6_loading0", l0, 1);
        chk("t6_wc0", wc0, 0);
        send_word(32'hCAFE0001, 0);
        send_word(HALT, 0);
        check_flags("t6b");

        // Randomized loads with random gaps and occasional mid-word restarts
        for (int r = 0; r < 12; r++) begin
            cyc(0, 1, 0, 8'h00);
            if ($urandom_range(0, 3) == 0) begin
                cyc(0, 0, 1, 8'($urandom));
                cyc(0, $urandom_range(0, 1) == 1, 1, 8'($urandom));
                cyc(0, 1, 0, 8'h00);
            end
            for (int i = $urandom_range(0, 5); i > 0; i--) send_word(rnd_word(), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 4) != 0) send_word(HALT, 1);
            check_flags("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
